// File: rtl/uart_pkg.sv
// Shared definitions for the UART transmit scheduler: FSM encoding and
// frame timing derived from the 14-clock bit period.
package uart_pkg;

  localparam int BIT_CLKS    = 14;
  localparam int FRAME_CLKS  = 11 * BIT_CLKS;
  // A full frame plus about three bit times of slack for the tx_done watchdog.
  localparam int TIMEOUT_DEF = FRAME_CLKS + 3 * BIT_CLKS + 4;

  typedef enum logic [1:0] {
    S_IDLE,
    S_START,
    S_WAIT_DONE,
    S_GAP
  } sched_state_t;

  function automatic int cnt_width(input int max_val);
    return (max_val < 2) ? 1 : $clog2(max_val + 1);
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin picker: the search starts one past the last winner and wraps,
// returning a one-hot grant plus the winner's index.
module rr_arbiter #(
  parameter int N = 3
) (
  input  logic [N-1:0] req,
  input  logic [1:0]   last,
  output logic [N-1:0] grant,
  output logic [1:0]   index
);

  logic [2:0] cand;
  logic       found;

  always_comb begin
    grant = '0;
    index = '0;
    found = 1'b0;
    cand  = '0;
    for (int k = 1; k <= N; k++) begin
      cand = 3'((int'(last) + k) % N);
      if (!found && req[cand[1:0]]) begin
        found             = 1'b1;
        grant[cand[1:0]]  = 1'b1;
        index             = cand[1:0];
      end
    end
  end

endmodule

// File: rtl/uart_tx_scheduler.sv
// Shares one uart_tx among N_REQ byte requesters: round-robin grant,
// start pulse, tx_done watchdog and a programmable inter-frame gap.
module uart_tx_scheduler
  import uart_pkg::*;
#(
  parameter int               N_REQ          = 3,
  parameter int               GAP_CYCLES     = 1,
  parameter int               TIMEOUT_CYCLES = TIMEOUT_DEF,
  parameter logic [N_REQ-1:0] PARITY_CFG     = '0
) (
  input  logic               clk_3125,
  input  logic               rst,
  input  logic [N_REQ-1:0]   req_valid,
  input  logic [8*N_REQ-1:0] req_data,
  output logic [N_REQ-1:0]   req_ready,
  output logic               tx_start,
  output logic [7:0]         data,
  output logic               parity_type,
  input  logic               tx_done,
  output logic [1:0]         owner,
  output logic               busy,
  output logic               timeout_err
);

  localparam int            CW       = cnt_width(TIMEOUT_CYCLES + GAP_CYCLES);
  localparam logic [CW-1:0] TO_LAST  = CW'(TIMEOUT_CYCLES - 1);
  localparam logic [CW-1:0] GAP_LAST = (GAP_CYCLES > 1) ? CW'(GAP_CYCLES - 2) : '0;

  sched_state_t     state;
  logic [CW-1:0]    cnt;
  logic [1:0]       last_owner;
  logic [N_REQ-1:0] grant;
  logic [1:0]       gidx;
  logic [7:0]       gbyte;
  logic             gpar;

  rr_arbiter #(.N(N_REQ)) u_arb (
    .req   (req_valid),
    .last  (last_owner),
    .grant (grant),
    .index (gidx)
  );

  always_comb begin
    gbyte = '0;
    for (int i = 0; i < N_REQ; i++)
      if (grant[i]) gbyte = req_data[8*i +: 8];
  end

  assign gpar = |(grant & PARITY_CFG);
  assign busy = (state != S_IDLE);

  // The tx_done cycle itself counts as the first idle clock, so GAP holds
  // GAP_CYCLES-1 cycles and GAP_CYCLES <= 1 returns straight to IDLE.
  always_ff @(posedge clk_3125) begin
    if (rst) begin
      state       <= S_IDLE;
      cnt         <= '0;
      tx_start    <= 1'b0;
      req_ready   <= '0;
      data        <= 8'h00;
      parity_type <= 1'b0;
      owner       <= 2'd0;
      timeout_err <= 1'b0;
      last_owner  <= 2'(N_REQ - 1);
    end else begin
      tx_start  <= 1'b0;
      req_ready <= '0;
      case (state)
        S_IDLE: begin
          if (|req_valid) begin
            req_ready   <= grant;
            data        <= gbyte;
            parity_type <= gpar;
            owner       <= gidx;
            last_owner  <= gidx;
            state       <= S_START;
          end
        end
        S_START: begin
          tx_start <= 1'b1;
          cnt      <= '0;
          state    <= S_WAIT_DONE;
        end
        S_WAIT_DONE: begin
          if (tx_done) begin
            cnt   <= '0;
            state <= (GAP_CYCLES > 1) ? S_GAP : S_IDLE;
          end else if (cnt == TO_LAST) begin
            timeout_err <= 1'b1;
            state       <= S_IDLE;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        S_GAP: begin
          if (cnt == GAP_LAST) state <= S_IDLE;
          else                 cnt   <= cnt + 1'b1;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx_scheduler.sv
// Randomized bench for uart_tx_scheduler: a uart_tx responder plus a
// transaction-level model predicting every output cycle by cycle.
module tb_uart_tx_scheduler;

  localparam int           N     = 3;
  localparam int           GAP   = 1;
  localparam int           TO    = 200;
  localparam int           FRAME = 154;
  localparam logic [N-1:0] CFG   = 3'b010;
  localparam int           BIG   = 32'h7fff_ffff;

  logic           clk_3125 = 1'b0;
  logic           rst, tx_done;
  logic [N-1:0]   req_valid, req_ready;
  logic [8*N-1:0] req_data;
  logic           tx_start, parity_type, busy, timeout_err;
  logic [7:0]     data;
  logic [1:0]     owner;

  always #160 clk_3125 = ~clk_3125;

  uart_tx_scheduler #(
    .N_REQ(N), .GAP_CYCLES(GAP), .TIMEOUT_CYCLES(TO), .PARITY_CFG(CFG)
  ) dut (
    .clk_3125    (clk_3125),
    .rst         (rst),
    .req_valid   (req_valid),
    .req_data    (req_data),
    .req_ready   (req_ready),
    .tx_start    (tx_start),
    .data        (data),
    .parity_type (parity_type),
    .tx_done     (tx_done),
    .owner       (owner),
    .busy        (busy),
    .timeout_err (timeout_err)
  );

  int n_checks = 0, n_errs = 0;
  int n = 0;

  // model: elig = first cycle whose req_valid may win a grant
  int elig = BIG, gtick = -1, stick = -1, busy_from = BIG, last = N - 1;
  logic [N-1:0] e_ready;
  logic         e_start, e_par, e_to, e_busy;
  logic [7:0]   e_data;
  logic [1:0]   e_owner;

  int done_at = -1, last_done = -1;
  bit withhold = 0, chk_spacing = 0, chk_owner = 0;
  int owner_q[$];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errs++;
      $display("FAIL %s tick %0d: got %0h expected %0h", tag, n, got, exp);
    end
  endtask

  function automatic int pick(input int from, input logic [N-1:0] v);
    for (int k = 1; k <= N; k++)
      if (v[(from + k) % N]) return (from + k) % N;
    return -1;
  endfunction

  task automatic cycle();
    logic [N-1:0]   pv;
    logic [8*N-1:0] pd;
    logic           prst, pdone;
    int             w;
    pv = req_valid; pd = req_data; prst = rst; pdone = tx_done;
    @(posedge clk_3125); #1;
    n++;
    e_ready = '0;
    e_start = 1'b0;
    if (prst) begin
      elig = n; gtick = -1; stick = -1; busy_from = BIG; last = N - 1;
      e_data = 8'h00; e_par = 1'b0; e_owner = 2'd0; e_to = 1'b0;
    end else begin
      if (stick >= 0 && pdone) begin
        elig  = n - 1 + ((GAP > 1) ? GAP : 1);
        stick = -1;
      end else if (stick >= 0 && n == stick + TO) begin
        e_to  = 1'b1;
        elig  = n;
        stick = -1;
      end
      if (gtick >= 0 && n == gtick + 1) begin
        e_start = 1'b1;
        stick   = n;
        gtick   = -1;
      end
      if (elig != BIG && n - 1 >= elig && pv != '0) begin
        w          = pick(last, pv);
        e_ready    = '0;
        e_ready[w] = 1'b1;
        e_data     = pd[w*8 +: 8];
        e_par      = CFG[w];
        e_owner    = 2'(w);
        last       = w;
        elig       = BIG;
        gtick      = n;
        busy_from  = n;
      end
    end
    e_busy = (n >= busy_from) && (n < elig);
    check("req_ready",   req_ready,   e_ready);
    check("tx_start",    tx_start,    e_start);
    check("data",        data,        e_data);
    check("parity_type", parity_type, e_par);
    check("owner",       owner,       e_owner);
    check("busy",        busy,        e_busy);
    check("timeout_err", timeout_err, e_to);
    // uart_tx responder
    if (tx_start === 1'b1) begin
      if (chk_spacing && last_done >= 0) check("done_to_start", n - last_done, GAP + 2);
      done_at = withhold ? -1 : n + FRAME;
    end
    if (chk_owner && req_ready !== '0) owner_q.push_back(int'(owner));
    tx_done = (n == done_at);
    if (tx_done) last_done = n;
  endtask

  task automatic do_reset();
    rst = 1'b1; done_at = -1;
    cycle();
    rst = 1'b0;
  endtask

  initial begin
    int exp_seq[4] = '{0, 1, 2, 0};
    rst = 1'b1; req_valid = '0; req_data = '0; tx_done = 1'b0;
    repeat (3) cycle();
    check("rst_busy", busy, 1'b0);
    rst = 1'b0;

    // first request after reset
    req_data[7:0] = 8'hA5; req_valid = 3'b001;
    cycle();
    check("first_ready", req_ready, 3'b001);
    req_valid = '0;
    cycle();
    check("first_start", tx_start, 1'b1);
    check("first_data", data, 8'hA5);
    check("first_par", parity_type, 1'b0);
    repeat (170) cycle();

    // all requesters continuously valid
    do_reset();
    last_done = -1; chk_spacing = 1; chk_owner = 1;
    req_valid = 3'b111;
    repeat (500) begin
      req_data = 24'($urandom);
      cycle();
    end
    req_valid = '0; chk_owner = 0;
    repeat (170) cycle();
    chk_spacing = 0;
    check("rr_frames", (owner_q.size() >= 4) ? 1 : 0, 1);
    for (int i = 0; i < 4 && i < owner_q.size(); i++) check("rr_owner", owner_q[i], exp_seq[i]);

    // per-requester parity
    do_reset();
    req_data[15:8] = 8'h3C; req_valid = 3'b010;
    cycle();
    req_valid = '0;
    cycle();
    check("par1_data", data, 8'h3C);
    check("par1_type", parity_type, 1'b1);
    repeat (170) cycle();
    req_data[23:16] = 8'h5A; req_valid = 3'b100;
    cycle();
    req_valid = '0;
    cycle();
    check("par2_type", parity_type, 1'b0);
    repeat (170) cycle();

    // missing tx_done
    withhold = 1; req_valid = 3'b001;
    cycle();
    req_valid = '0;
    repeat (210) cycle();
    check("timeout_set", timeout_err, 1'b1);
    check("timeout_idle", busy, 1'b0);
    withhold = 0; req_valid = 3'b100;
    cycle();
    check("after_to_ready", req_ready, 3'b100);
    req_valid = '0;
    repeat (170) cycle();

    // reset in the middle of a frame, late tx_done must be ignored
    req_valid = 3'b001;
    cycle();
    req_valid = '0;
    repeat (51) cycle();
    rst = 1'b1;
    cycle();
    rst = 1'b0;
    check("midrst_busy", busy, 1'b0);
    check("midrst_data", data, 8'h00);
    check("midrst_to", timeout_err, 1'b0);
    repeat (150) cycle();
    check("late_done_busy", busy, 1'b0);

    // spurious tx_done while idle
    repeat (5) begin
      tx_done = 1'b1;
      cycle();
      check("spur_ready", req_ready, 3'b000);
    end

    // random traffic
    repeat (6000) begin
      for (int b = 0; b < N; b++) req_valid[b] = ($urandom_range(0, 7) < 3);
      req_data = 24'($urandom);
      withhold = ($urandom_range(0, 9) == 0);
      rst = ($urandom_range(0, 999) == 0);
      cycle();
      if ($urandom_range(0, 99) == 0) tx_done = 1'b1;
    end
    rst = 1'b0; req_valid = '0;
    repeat (5) cycle();

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errs);
    $finish;
  end

endmodule
